// File: rtl/pixel_replicate.sv
// pixel_replicate: nearest-neighbour upscaler (x1 / x2 / x4).
// Scans the output frame in raster order. For every output pixel it issues
// one read of the source pixel it maps to, then writes the returned pixel to
// the output framebuffer at the raster index. The pipeline runs at one pixel
// per cycle with a fixed read-to-write latency of MEM_LATENCY + 1 cycles.
//
// Ports:
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   start            one-cycle frame request, accepted only when idle
//   zoom_level       0 = x1, 1 = x2, 2..7 = x4; sampled when start is accepted
//   pixel_in         source memory data, MEM_LATENCY cycles after read_addr
//   read_addr/rd_en  source memory read port
//   pixel_out/write_addr/write_en  destination framebuffer write port
//   busy             high while a frame is being processed
//   done             one-cycle pulse after the final write
module pixel_replicate #(
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120,
  parameter int PIXEL_W       = 8,
  parameter int RD_ADDR_W     = 15,
  parameter int WR_ADDR_W     = 19,
  parameter int MEM_LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           zoom_level,
  input  logic [PIXEL_W-1:0]   pixel_in,
  output logic [RD_ADDR_W-1:0] read_addr,
  output logic                 rd_en,
  output logic [PIXEL_W-1:0]   pixel_out,
  output logic [WR_ADDR_W-1:0] write_addr,
  output logic                 write_en,
  output logic                 busy,
  output logic                 done
);

  // Counters must hold the x4 output extents (e.g. 640 and 480).
  localparam int XW = $clog2(IMG_WIDTH_IN * 4 + 1);
  localparam int YW = $clog2(IMG_HEIGHT_IN * 4 + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Out-of-range zoom codes saturate to the largest factor.
  function automatic logic [1:0] clamp_zoom(input logic [2:0] z);
    case (z)
      3'd0:    return 2'd0;
      3'd1:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  logic [1:0]           state;
  logic [1:0]           shift;
  logic [1:0]           shift_cur;
  logic [XW-1:0]        x;
  logic [XW-1:0]        w_out;
  logic [YW-1:0]        y;
  logic [YW-1:0]        h_out;
  logic [WR_ADDR_W-1:0] k;
  logic                 issue;
  logic                 last_px;
  logic [RD_ADDR_W-1:0] src_addr;

  logic [WR_ADDR_W-1:0] wa_p0;
  logic                 vld_p0;
  logic [WR_ADDR_W-1:0] wa_p1 [MEM_LATENCY];
  logic [MEM_LATENCY-1:0] vld_p1;

  // The read for pixel 0 is issued on the same edge that accepts start, so
  // while idle the scale factor comes straight from the (clamped) input.
  always_comb begin
    shift_cur = (state == S_IDLE) ? clamp_zoom(zoom_level) : shift;
    w_out     = XW'(IMG_WIDTH_IN) << shift_cur;
    h_out     = YW'(IMG_HEIGHT_IN) << shift_cur;
    issue     = (state == S_RUN) || ((state == S_IDLE) && start);
    last_px   = (x == w_out - XW'(1)) && (y == h_out - YW'(1));
    src_addr  = RD_ADDR_W'(y >> shift_cur) * RD_ADDR_W'(IMG_WIDTH_IN)
              + RD_ADDR_W'(x >> shift_cur);
  end

  // FSM and output-coordinate counters; x/y/k point at the next pixel to read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      shift <= 2'd0;
      x     <= '0;
      y     <= '0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift <= shift_cur;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (last_px) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Final write is on the port and nothing follows it in the pipe.
          if (write_en && !vld_p1[MEM_LATENCY-1]) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (issue) begin
        if (last_px) begin
          x <= '0;
          y <= '0;
          k <= '0;
        end else begin
          k <= k + WR_ADDR_W'(1);
          if (x == w_out - XW'(1)) begin
            x <= '0;
            y <= y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end
    end
  end

  // Stage p0: read issue. Stage p1[i]: waiting on memory latency. Then write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0     <= 1'b0;
      vld_p1     <= '0;
      write_en   <= 1'b0;
      read_addr  <= '0;
      write_addr <= '0;
      pixel_out  <= '0;
    end else begin
      vld_p0    <= issue;
      vld_p1[0] <= vld_p0;
      for (int i = 1; i < MEM_LATENCY; i++) vld_p1[i] <= vld_p1[i-1];
      write_en  <= vld_p1[MEM_LATENCY-1];
      if (issue) read_addr <= src_addr;
      if (vld_p1[MEM_LATENCY-1]) begin
        write_addr <= wa_p1[MEM_LATENCY-1];
        pixel_out  <= pixel_in;
      end
    end
  end

  // Destination address travels with the read; qualified by the vld chain.
  always_ff @(posedge clk) begin
    if (issue) wa_p0 <= k;
    wa_p1[0] <= wa_p0;
    for (int i = 1; i < MEM_LATENCY; i++) wa_p1[i] <= wa_p1[i-1];
  end

  assign rd_en = vld_p0;
  assign busy  = (state == S_RUN) || (state == S_DRAIN);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_pixel_replicate.sv
// Bench for pixel_replicate, using a reduced source frame so that full x4
// frames fit a short run. The source memory is filled with random bytes and
// every cycle of each frame is compared against the timing/addressing rules.
module tb_pixel_replicate;

  localparam int W  = 32;
  localparam int H  = 24;
  localparam int ML = 2;
  localparam int PW = 8;
  localparam int RW = 15;
  localparam int WW = 19;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [2:0]    zoom_level;
  logic [PW-1:0] pixel_in;
  logic [RW-1:0] read_addr;
  logic          rd_en;
  logic [PW-1:0] pixel_out;
  logic [WW-1:0] write_addr;
  logic          write_en;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [PW-1:0] mem [W*H];
  logic [PW-1:0] dq  [ML];

  pixel_replicate #(
    .IMG_WIDTH_IN (W),
    .IMG_HEIGHT_IN(H),
    .PIXEL_W      (PW),
    .RD_ADDR_W    (RW),
    .WR_ADDR_W    (WW),
    .MEM_LATENCY  (ML)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .zoom_level(zoom_level),
    .pixel_in  (pixel_in),
    .read_addr (read_addr),
    .rd_en     (rd_en),
    .pixel_out (pixel_out),
    .write_addr(write_addr),
    .write_en  (write_en),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source memory with ML cycles of read latency.
  always @(posedge clk) begin
    dq[0] <= mem[int'(read_addr) % (W*H)];
    for (int i = 1; i < ML; i++) dq[i] <= dq[i-1];
  end
  assign pixel_in = dq[ML-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Source pixel index for output raster index idx at scale shift s.
  function automatic int src_of(input int idx, input int s);
    int wo;
    wo = W << s;
    return ((idx / wo) >> s) * W + ((idx % wo) >> s);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read_addr"},  32'(read_addr),  0);
    chk({tag, "_rd_en"},      32'(rd_en),      0);
    chk({tag, "_pixel_out"},  32'(pixel_out),  0);
    chk({tag, "_write_addr"}, 32'(write_addr), 0);
    chk({tag, "_write_en"},   32'(write_en),   0);
    chk({tag, "_busy"},       32'(busy),       0);
    chk({tag, "_done"},       32'(done),       0);
  endtask

  // One frame. restart_at: cycle with an extra start pulse (0 = none).
  // zchg_at: cycle where zoom_level is forced to 0 (0 = none).
  // abort_w: assert reset right after this many writes (-1 = none).
  task automatic run_frame(input int zoom, input int restart_at, input int zchg_at,
                           input int abort_w);
    int s, n, c, writes, dones, last_wa, ridx, widx;
    bit aborted;
    s = (zoom == 0) ? 0 : (zoom == 1) ? 1 : 2;
    n = (W << s) * (H << s);
    @(negedge clk);
    start = 1'b1;
    zoom_level = 3'(zoom);
    c = 0; writes = 0; dones = 0; last_wa = -1; aborted = 0;
    while (c < n + ML + 4 && !aborted) begin
      @(negedge clk);
      c++;
      ridx = c - 1;
      widx = c - 2 - ML;
      chk("rd_en", 32'(rd_en), 32'(ridx >= 0 && ridx < n));
      if (ridx >= 0 && ridx < n) chk("read_addr", 32'(read_addr), 32'(src_of(ridx, s)));
      chk("write_en", 32'(write_en), 32'(widx >= 0 && widx < n));
      if (widx >= 0 && widx < n) begin
        chk("write_addr", 32'(write_addr), 32'(widx));
        chk("pixel_out", 32'(pixel_out), 32'(mem[src_of(widx, s)]));
      end
      chk("busy", 32'(busy), 32'(c >= 1 && c <= n + 1 + ML));
      chk("done", 32'(done), 32'(c == n + 2 + ML));
      if (write_en) begin
        writes++;
        last_wa = int'(write_addr);
      end
      if (done) dones++;
      start = (c == restart_at);
      if (c == zchg_at) zoom_level = 3'd0;
      if (abort_w >= 0 && writes == abort_w) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero("abort");
        aborted = 1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("write_count", 32'(writes), 32'(n));
      chk("last_write_addr", 32'(last_wa), 32'(n - 1));
      chk("done_count", 32'(dones), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < W*H; i++) mem[i] = PW'($urandom);
    rst_n = 1'b0;
    start = 1'b0;
    zoom_level = 3'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // x1 with an ignored second start mid-frame
    run_frame(0, 100, 0, -1);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    // x2
    run_frame(1, 0, 0, -1);
    // x4
    run_frame(2, 0, 0, -1);
    // code 5 behaves as x4; zoom_level change after acceptance has no effect
    run_frame(5, 0, 50, -1);

    // abort a x2 frame part-way, then a fresh full frame
    run_frame(1, 0, 0, 500);
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold_done", 32'(done), 0);
      chk("abort_hold_write_en", 32'(write_en), 0);
    end
    rst_n = 1'b1;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    run_frame(1, 0, 0, -1);

    // refresh memory contents and run x1 again
    for (int i = 0; i < W*H; i++) mem[i] = PW'($urandom);
    run_frame(0, 0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
